// File: rtl/adder_iterative_ctrl_if.sv
// Operand/result stream bundle for the iterative nibble-serial adder.
// master: operand producer and result consumer; slave: the adder controller.
interface adder_iterative_ctrl_if #(
    parameter int NBITS = 32
);
    logic             istream_val;
    logic             istream_rdy;
    logic [NBITS-1:0] in0;
    logic [NBITS-1:0] in1;
    logic             cin;
    logic             ostream_val;
    logic             ostream_rdy;
    logic [NBITS-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output istream_val, in0, in1, cin, ostream_rdy,
        input  istream_rdy, ostream_val, sum, cout, ovf, busy
    );

    modport slave (
        input  istream_val, in0, in1, cin, ostream_rdy,
        output istream_rdy, ostream_val, sum, cout, ovf, busy
    );
endinterface

// File: rtl/adder_iterative_ctrl.sv
// NBITS-wide add built from one 4-bit ripple slice stepped LSB nibble first.
// Ports: clk, rst (async, active-high), io (slave: val/rdy in, val/rdy out).
module adder_rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module adder_iterative_ctrl #(
    parameter int NBITS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_iterative_ctrl_if.slave io
);
    localparam int NSLICE = NBITS / 4;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [NBITS-1:0] s_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             sa_q;
    logic             sb_q;

    logic             val_q;
    logic [NBITS-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;

    logic [3:0]       add_s;
    logic             add_c;

    adder_rca4 u_slice (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .cin  (c_q),
        .sum  (add_s),
        .cout (add_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            val_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io.istream_val) begin
                        a_q     <= io.in0;
                        b_q     <= io.in1;
                        c_q     <= io.cin;
                        cnt_q   <= '0;
                        sa_q    <= io.in0[NBITS-1];
                        sb_q    <= io.in1[NBITS-1];
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    s_q   <= {add_s, s_q[NBITS-1:4]};
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    c_q   <= add_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Result regs load on the final step so the
                        // outputs come straight from flops in DONE.
                        state_q <= DONE;
                        val_q   <= 1'b1;
                        sum_q   <= {add_s, s_q[NBITS-1:4]};
                        cout_q  <= add_c;
                        ovf_q   <= (sa_q == sb_q) & (add_s[3] != sa_q);
                    end
                end
                DONE: begin
                    if (io.ostream_rdy) begin
                        state_q <= IDLE;
                        val_q   <= 1'b0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign io.istream_rdy = (state_q == IDLE);
    assign io.ostream_val = val_q;
    assign io.sum         = sum_q;
    assign io.cout        = cout_q;
    assign io.ovf         = ovf_q;
    assign io.busy        = busy_q;
endmodule

// File: tb/tb_adder_iterative_ctrl.sv
// Directed and random checks of the iterative nibble-serial adder.
// Drives/samples 1 time unit after each rising edge of clk.
module tb_adder_iterative_ctrl;
    localparam int NBITS = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder_iterative_ctrl_if #(.NBITS(NBITS)) io ();

    adder_iterative_ctrl #(.NBITS(NBITS)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for ostream_val; returns edges waited (bounded).
    task automatic wait_val(output int edges);
        edges = 0;
        while (!io.ostream_val && edges < 50) begin
            step();
            edges++;
        end
        chk("val_timeout", {63'd0, io.ostream_val}, 64'd1);
    endtask

    // One transaction: offer, wait result, hold off rdy, then consume.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic c, input int hold,
                          output logic [31:0] s, output logic co,
                          output logic ov, output int lat);
        int n;
        n = 0;
        while (!io.istream_rdy && n < 50) begin
            step();
            n++;
        end
        chk("rdy_timeout", {63'd0, io.istream_rdy}, 64'd1);
        io.in0 = a;
        io.in1 = b;
        io.cin = c;
        io.istream_val = 1'b1;
        step();
        io.istream_val = 1'b0;
        wait_val(lat);
        s  = io.sum;
        co = io.cout;
        ov = io.ovf;
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_val", {63'd0, io.ostream_val}, 64'd1);
            chk("hold_sum", {32'd0, io.sum}, {32'd0, s});
        end
        io.ostream_rdy = 1'b1;
        step();
        io.ostream_rdy = 1'b0;
        chk("drop_val", {63'd0, io.ostream_val}, 64'd0);
        chk("back_rdy", {63'd0, io.istream_rdy}, 64'd1);
    endtask

    initial begin
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          lat;
        logic [31:0] s0;
        logic        co0;
        logic        ov0;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic [32:0] gold;
        logic        gov;
        int          seen;

        checks = 0;
        errors = 0;
        io.istream_val = 1'b0;
        io.ostream_rdy = 1'b0;
        io.in0 = '0;
        io.in1 = '0;
        io.cin = 1'b0;

        // 1. reset then basic add
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_val", {63'd0, io.ostream_val}, 64'd0);
        chk("rst_sum", {32'd0, io.sum}, 64'd0);
        chk("rst_cout", {63'd0, io.cout}, 64'd0);
        chk("rst_ovf", {63'd0, io.ovf}, 64'd0);
        chk("rst_busy", {63'd0, io.busy}, 64'd0);
        chk("idle_rdy", {63'd0, io.istream_rdy}, 64'd1);
        run_op(32'h5, 32'h3, 1'b0, 0, s, co, ov, lat);
        // accept cycle is cycle 0; val must show in cycle 9
        chk("latency", 64'(lat + 1), 64'd9);
        chk("t1_sum", {32'd0, s}, 64'h8);
        chk("t1_cout", {63'd0, co}, 64'd0);
        chk("t1_ovf", {63'd0, ov}, 64'd0);
        chk("idle_sum", {32'd0, io.sum}, 64'd0);

        // 2. carry ripple
        run_op(32'hFFFFFFFF, 32'h0, 1'b1, 1, s, co, ov, lat);
        chk("t2a_sum", {32'd0, s}, 64'h0);
        chk("t2a_cout", {63'd0, co}, 64'd1);
        chk("t2a_ovf", {63'd0, ov}, 64'd0);
        run_op(32'hF, 32'h1, 1'b0, 0, s, co, ov, lat);
        chk("t2b_sum", {32'd0, s}, 64'h10);

        // 3. signed overflow
        run_op(32'h7FFFFFFF, 32'h1, 1'b0, 0, s, co, ov, lat);
        chk("t3a_sum", {32'd0, s}, 64'h80000000);
        chk("t3a_cout", {63'd0, co}, 64'd0);
        chk("t3a_ovf", {63'd0, ov}, 64'd1);
        run_op(32'h80000000, 32'h80000000, 1'b0, 0, s, co, ov, lat);
        chk("t3b_sum", {32'd0, s}, 64'h0);
        chk("t3b_cout", {63'd0, co}, 64'd1);
        chk("t3b_ovf", {63'd0, ov}, 64'd1);

        // 4. backpressure with istream_val held high
        io.in0 = 32'h7FFFFFFF;
        io.in1 = 32'h7FFFFFFF;
        io.cin = 1'b1;
        io.istream_val = 1'b1;
        step();
        io.in0 = 32'h00000100;
        io.in1 = 32'h00000200;
        io.cin = 1'b0;
        wait_val(lat);
        chk("t4_sum", {32'd0, io.sum}, 64'hFFFFFFFF);
        chk("t4_cout", {63'd0, io.cout}, 64'd0);
        chk("t4_ovf", {63'd0, io.ovf}, 64'd1);
        s0 = io.sum;
        co0 = io.cout;
        ov0 = io.ovf;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_val", {63'd0, io.ostream_val}, 64'd1);
            chk("bp_sum", {32'd0, io.sum}, {32'd0, s0});
            chk("bp_cout", {63'd0, io.cout}, {63'd0, co0});
            chk("bp_ovf", {63'd0, io.ovf}, {63'd0, ov0});
            chk("bp_irdy", {63'd0, io.istream_rdy}, 64'd0);
        end
        io.ostream_rdy = 1'b1;
        step();
        io.ostream_rdy = 1'b0;
        chk("bp_idle", {63'd0, io.istream_rdy}, 64'd1);
        chk("bp_drop", {63'd0, io.ostream_val}, 64'd0);
        step();
        io.istream_val = 1'b0;
        chk("bp_acc_busy", {63'd0, io.busy}, 64'd1);
        chk("bp_acc_rdy", {63'd0, io.istream_rdy}, 64'd0);
        wait_val(lat);
        chk("t4b_sum", {32'd0, io.sum}, 64'h300);
        io.ostream_rdy = 1'b1;
        step();
        io.ostream_rdy = 1'b0;

        // 5. reset in CALC cycle 4
        io.in0 = 32'h12345678;
        io.in1 = 32'h11111111;
        io.cin = 1'b0;
        io.istream_val = 1'b1;
        step();
        io.istream_val = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_busy", {63'd0, io.busy}, 64'd0);
        chk("mid_val", {63'd0, io.ostream_val}, 64'd0);
        step();
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (io.ostream_val) seen++;
        end
        chk("mid_noval", 64'(seen), 64'd0);
        chk("mid_rdy", {63'd0, io.istream_rdy}, 64'd1);
        run_op(32'h12345678, 32'h11111111, 1'b0, 0, s, co, ov, lat);
        chk("t5_sum", {32'd0, s}, 64'h23456789);

        // 6. random with stalls
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            gold = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            gov = (ra[31] == rb[31]) && (gold[31] != ra[31]);
            for (int d = $urandom_range(0, 2); d > 0; d--) step();
            run_op(ra, rb, rc, $urandom_range(0, 2), s, co, ov, lat);
            chk("rnd_sum", {32'd0, s}, {32'd0, gold[31:0]});
            chk("rnd_cout", {63'd0, co}, {63'd0, gold[32]});
            chk("rnd_ovf", {63'd0, ov}, {63'd0, gov});
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
